quadratic_solver_seq: RTL and testbench
=======================================

# quadratic_solver_seq

Multi-cycle, parametrised signed-integer solver for a·x² + b·x + c = 0. It is the sequential successor to the team's combinational solver. It accepts coefficients of configurable width through a start/busy/done handshake and computes the discriminant. It then takes a bit-serial integer square root and runs a shared restoring divider, so the block closes timing at any W. It sits behind the coefficient register bank and reports roots plus a case status to the result formatter.

## Interface
- W, 8, coefficient width (signed, ≥3)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- a, b, c  in  W each  signed coefficients, sampled on accept edge
- busy  out  1  high from accept edge until done cycle inclusive
- done  out  1  one-cycle pulse, results valid from this cycle
- x1, x2  out  W+1 each  signed roots
- status  out  2  00 two real roots, 01 no real root, 10 linear, 11 degenerate (a=b=0)
- exact  out  1  present only with QSOLVER_EXACT_EN

## Operation
- States: IDLE, DELTA, SQRT, DIV1, DIV2, DONE.
- IDLE: on start=1, latch a, b, c, set busy, go to DELTA. start while busy is ignored; no queueing.
- DELTA (1 cycle): delta = b² − 4ac in 2W+3 signed bits; no overflow is possible.
  - a=0, b≠0 → DIV1 (linear).
  - a=0, b=0 → DONE with status 11.
  - delta<0 → DONE with status 01.
  - else → SQRT.
- SQRT (W+1 cycles): restoring bit-pair floor square root, one result bit per cycle, MSB first. s = floor(√delta), W+1 bits unsigned.
- DIV1 (W+1 cycles):
  - Quadratic: x1 = (−b + s) / (2a).
  - Linear: x1 = (−c) / b, and x2 = x1; then go to DONE.
- DIV2 (W+1 cycles): x2 = (−b − s) / (2a).
- Divider rules:
  - Magnitudes first, unsigned restoring, one quotient bit per cycle.
  - Sign applied afterwards.
  - Quotient truncated toward zero, matching Verilog `/` semantics.
  - Numerator magnitude < 2^(W+1), so every quotient fits W+1 signed bits.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- Outputs x1, x2, status are registered and hold their values until the next DONE.
- Status 01/11: x1=x2=0.
- Reset values: busy=0, done=0, x1=0, x2=0, status=00, exact=0, state IDLE. Reset mid-operation aborts with no done pulse; outputs return to reset values.

## Timing
- Accept edge is T0 (start=1, busy=0). busy rises after T0.
- done is high in the cycle following edge T0+L:
  - Quadratic, delta≥0: L = 3(W+1)+2. For W=8, L=29.
  - Linear: L = (W+1)+2. For W=8, L=11.
  - Degenerate or delta<0: L = 2.
- Latency is fixed per case; it does not depend on data within a case.
- busy falls at the edge ending the done cycle. start may be reasserted in that same cycle; it is accepted at that edge (back-to-back throughput).

## Configuration
- QSOLVER_EXACT_EN defined: adds the exact output.
  - exact=1 at done when the computed roots are mathematically exact: delta is a perfect square (SQRT remainder 0) and every executed division has remainder 0.
  - exact=0 for status 01/11.
- Undefined: no exact port. The remainder-zero tracking logic is absent. All other behaviour is identical.

## Test plan
- W=8, a=1, b=−3, c=2 → delta=1, x1=2, x2=1, status 00, done exactly 29 cycles after accept; exact=1.
- a=1, b=1, c=−1 → s=2, x1=0, x2=−1 (truncation of −3/2), status 00, exact=0.
- a=1, b=0, c=1 → status 01, x1=x2=0, done 2 cycles after accept. a=0, b=0, c=5 → status 11 in 2 cycles.
- a=0, b=2, c=−6 → x1=x2=3, status 10, done 11 cycles after accept. Extremes a=−128, b=−128, c=127 → no overflow, results match a reference model.
- Start held high continuously → accepts only at busy=0, back-to-back; start pulsed mid-SQRT is ignored, inputs changed mid-run do not affect the results.
- Assert rst at cycle 10 of a quadratic run → all outputs 0 immediately, no done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/quadratic_solver_seq.sv
// Sequential signed-integer quadratic solver: discriminant, bit-serial sqrt and a shared restoring divider.
// Optional `QSOLVER_EXACT_EN adds the exact output (perfect square and zero division remainders).
module quadratic_solver_seq #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic         busy,
    output logic         done,
    output logic [W:0]   x1,
    output logic [W:0]   x2,
    output logic [1:0]   status
`ifdef QSOLVER_EXACT_EN
    ,
    output logic         exact
`endif
);

    localparam int unsigned DW = 2 * W + 3;
    localparam int unsigned NW = W + 2;
    localparam int unsigned SW = W + 5;
    localparam int unsigned CW = $clog2(W + 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DELTA = 3'd1;
    localparam logic [2:0] S_SQRT  = 3'd2;
    localparam logic [2:0] S_DIV1  = 3'd3;
    localparam logic [2:0] S_DIV2  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    function automatic logic [W:0] mag(input logic signed [NW-1:0] v);
        return (W+1)'(v[NW-1] ? -v : v);
    endfunction

    logic [2:0]            state_q, state_d;
    logic signed [W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*W+1:0]        rad_q, rad_d;
    logic [W:0]            root_q, root_d;
    logic [W+2:0]          srem_q, srem_d;
    logic [W:0]            num_q, num_d, den_q, den_d, drem_q, drem_d;
    logic [W-1:0]          quo_q, quo_d;
    logic                  neg_q, neg_d, linear_q, linear_d;
    logic [W:0]            r1_q, r1_d, r2_q, r2_d;
    logic [1:0]            sts_q, sts_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [W:0]            x1_q, x1_d, x2_q, x2_d;
    logic [1:0]            status_q, status_d;

    logic signed [DW-1:0]  bb_c, ac_c, delta_c;
    logic signed [NW-1:0]  nb_c, nc_c, bden_c, aden_c, num1_c, num2_c;
    logic [SW-1:0]         scur, stv;
    logic                  sge, dge, last;
    logic [W+2:0]          srem_n;
    logic [W:0]            root_n, drem_n, quo_n, quo_s;
    logic [W+1:0]          dtrial;

    // Discriminant and divider operands from the latched coefficients
    always_comb begin
        bb_c    = DW'(b_q) * DW'(b_q);
        ac_c    = DW'(a_q) * DW'(c_q);
        delta_c = bb_c - (ac_c <<< 2);
        nb_c    = -NW'(b_q);
        nc_c    = -NW'(c_q);
        bden_c  = NW'(b_q);
        aden_c  = NW'(a_q) <<< 1;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        rad_d    = rad_q;
        root_d   = root_q;
        srem_d   = srem_q;
        num_d    = num_q;
        den_d    = den_q;
        drem_d   = drem_q;
        quo_d    = quo_q;
        neg_d    = neg_q;
        linear_d = linear_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        sts_d    = sts_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        x1_d     = x1_q;
        x2_d     = x2_q;
        status_d = status_q;

        // One bit-pair of the restoring square root
        scur   = {srem_q, rad_q[2*W+1 -: 2]};
        stv    = {2'b00, root_q, 2'b01};
        sge    = (scur >= stv);
        srem_n = (W+3)'(sge ? scur - stv : scur);
        root_n = {root_q[W-1:0], sge};

        // One quotient bit of the unsigned restoring divider
        dtrial = {drem_q, num_q[W]};
        dge    = (dtrial >= {1'b0, den_q});
        drem_n = (W+1)'(dge ? dtrial - {1'b0, den_q} : dtrial);
        quo_n  = {quo_q, dge};
        quo_s  = neg_q ? -quo_n : quo_n;

        num1_c = nb_c + $signed({1'b0, root_n});
        num2_c = nb_c - $signed({1'b0, root_q});
        last   = (cnt_q == CW'(W));

        if (done_q) busy_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = c;
                    busy_d  = 1'b1;
                    state_d = S_DELTA;
                end
            end
            S_DELTA: begin
                cnt_d  = '0;
                r1_d   = '0;
                r2_d   = '0;
                if (a_q == '0 && b_q == '0) begin
                    sts_d   = 2'b11;
                    state_d = S_DONE;
                end else if (a_q == '0) begin
                    sts_d    = 2'b10;
                    linear_d = 1'b1;
                    num_d    = mag(nc_c);
                    den_d    = mag(bden_c);
                    neg_d    = nc_c[NW-1] ^ bden_c[NW-1];
                    drem_d   = '0;
                    quo_d    = '0;
                    state_d  = S_DIV1;
                end else if (delta_c[DW-1]) begin
                    sts_d   = 2'b01;
                    state_d = S_DONE;
                end else begin
                    sts_d    = 2'b00;
                    linear_d = 1'b0;
                    rad_d    = delta_c[2*W+1:0];
                    root_d   = '0;
                    srem_d   = '0;
                    state_d  = S_SQRT;
                end
            end
            S_SQRT: begin
                rad_d  = {rad_q[2*W-1:0], 2'b00};
                root_d = root_n;
                srem_d = srem_n;
                cnt_d  = cnt_q + 1'b1;
                if (last) begin
                    cnt_d   = '0;
                    num_d   = mag(num1_c);
                    den_d   = mag(aden_c);
                    neg_d   = num1_c[NW-1] ^ aden_c[NW-1];
                    drem_d  = '0;
                    quo_d   = '0;
                    state_d = S_DIV1;
                end
            end
            S_DIV1, S_DIV2: begin
                num_d  = {num_q[W-1:0], 1'b0};
                drem_d = drem_n;
                quo_d  = quo_n[W-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (last && state_q == S_DIV2) begin
                    r2_d    = quo_s;
                    state_d = S_DONE;
                end else if (last && linear_q) begin
                    r1_d    = quo_s;
                    r2_d    = quo_s;
                    state_d = S_DONE;
                end else if (last) begin
                    r1_d    = quo_s;
                    cnt_d   = '0;
                    num_d   = mag(num2_c);
                    den_d   = mag(aden_c);
                    neg_d   = num2_c[NW-1] ^ aden_c[NW-1];
                    drem_d  = '0;
                    quo_d   = '0;
                    state_d = S_DIV2;
                end
            end
            S_DONE: begin
                x1_d     = r1_q;
                x2_d     = r2_q;
                status_d = sts_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            rad_q    <= '0;
            root_q   <= '0;
            srem_q   <= '0;
            num_q    <= '0;
            den_q    <= '0;
            drem_q   <= '0;
            quo_q    <= '0;
            neg_q    <= 1'b0;
            linear_q <= 1'b0;
            r1_q     <= '0;
            r2_q     <= '0;
            sts_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            x1_q     <= '0;
            x2_q     <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            rad_q    <= rad_d;
            root_q   <= root_d;
            srem_q   <= srem_d;
            num_q    <= num_d;
            den_q    <= den_d;
            drem_q   <= drem_d;
            quo_q    <= quo_d;
            neg_q    <= neg_d;
            linear_q <= linear_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            sts_q    <= sts_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            status_q <= status_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign x1     = x1_q;
    assign x2     = x2_q;
    assign status = status_q;

`ifdef QSOLVER_EXACT_EN
    logic ex_q, ex_d, exact_q, exact_d;

    // Exactness accumulates across the sqrt and every division actually executed
    always_comb begin
        ex_d    = ex_q;
        exact_d = exact_q;
        case (state_q)
            S_DELTA:        ex_d = (a_q == '0 && b_q != '0) || (a_q != '0 && !delta_c[DW-1]);
            S_SQRT:         if (last) ex_d = ex_q & (srem_n == '0);
            S_DIV1, S_DIV2: if (last) ex_d = ex_q & (drem_n == '0);
            S_DONE:         exact_d = ex_q;
            default:        ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= 1'b0;
            exact_q <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            exact_q <= exact_d;
        end
    end

    assign exact = exact_q;
`endif

endmodule

// File: tb/tb_quadratic_solver_seq.sv
// Self-checking bench for quadratic_solver_seq: vector table, random vs. arithmetic model, corner sequences.
module tb_quadratic_solver_seq;

    localparam int W  = 8;
    localparam int LQ = 3 * (W + 1) + 2;
    localparam int LL = (W + 1) + 2;
    localparam int LS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b, c;
    logic         busy, done;
    logic [W:0]   x1, x2;
    logic [1:0]   status;
`ifdef QSOLVER_EXACT_EN
    logic         exact;
`endif

    quadratic_solver_seq #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .c      (c),
        .busy   (busy),
        .done   (done),
        .x1     (x1),
        .x2     (x2),
        .status (status)
`ifdef QSOLVER_EXACT_EN
        ,
        .exact  (exact)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    typedef struct {
        int a, b, c;
        int x1, x2, st, lat, ex;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int to_int(input logic [W:0] v);
        return int'($signed(v));
    endfunction

    function automatic int isqrt(input int d);
        int s;
        s = 0;
        while ((s + 1) * (s + 1) <= d) s++;
        return s;
    endfunction

    // Reference: plain integer algebra, '/' truncates toward zero
    task automatic model(input int ai, input int bi, input int ci,
                         output int x1e, output int x2e, output int ste,
                         output int late, output int exe);
        int d, s;
        x1e = 0; x2e = 0; exe = 0;
        if (ai == 0 && bi == 0) begin
            ste = 3; late = LS;
        end else if (ai == 0) begin
            ste = 2; late = LL;
            x1e = (-ci) / bi; x2e = x1e;
            exe = ((-ci) % bi == 0) ? 1 : 0;
        end else begin
            d = bi * bi - 4 * ai * ci;
            if (d < 0) begin
                ste = 1; late = LS;
            end else begin
                s = isqrt(d);
                ste = 0; late = LQ;
                x1e = (-bi + s) / (2 * ai);
                x2e = (-bi - s) / (2 * ai);
                exe = (s * s == d && (-bi + s) % (2 * ai) == 0 && (-bi - s) % (2 * ai) == 0) ? 1 : 0;
            end
        end
    endtask

    task automatic wait_done(input string nm, output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        if (!done) chk({nm, " done-timeout"}, 0, 1);
    endtask

    task automatic run_one(input string nm, input int ai, input int bi, input int ci,
                           input int x1e, input int x2e, input int ste,
                           input int late, input int exe);
        int cyc;
        @(negedge clk);
        a = W'(ai); b = W'(bi); c = W'(ci);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
        wait_done(nm, cyc);
        chk({nm, " latency"}, cyc, late);
        chk({nm, " x1"}, to_int(x1), x1e);
        chk({nm, " x2"}, to_int(x2), x2e);
        chk({nm, " status"}, int'(status), ste);
`ifdef QSOLVER_EXACT_EN
        chk({nm, " exact"}, int'(exact), exe);
`endif
    endtask

    initial begin
        int cyc, drops, pulses;
        int ai, bi, ci, x1e, x2e, ste, late, exe;
        logic signed [W-1:0] r;

        n_cmp = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;

        tbl[0]  = '{1, -3, 2, 2, 1, 0, LQ, 1};
        tbl[1]  = '{1, 1, -1, 0, -1, 0, LQ, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 1, LS, 0};
        tbl[3]  = '{0, 0, 5, 0, 0, 3, LS, 0};
        tbl[4]  = '{0, 2, -6, 3, 3, 2, LL, 1};
        tbl[5]  = '{-128, -128, 127, -1, 0, 0, LQ, 0};
        tbl[6]  = '{2, -4, 2, 1, 1, 0, LQ, 1};
        tbl[7]  = '{-1, 0, 4, -2, 2, 0, LQ, 1};
        tbl[8]  = '{0, -3, 7, 2, 2, 2, LL, 0};
        tbl[9]  = '{0, -128, -128, -1, -1, 2, LL, 1};
        tbl[10] = '{-128, 127, -128, 0, 0, 1, LS, 0};

        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset x1", to_int(x1), 0);
        chk("reset x2", to_int(x2), 0);
        chk("reset status", int'(status), 0);
        rst = 1'b0;

        foreach (tbl[i])
            run_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c,
                    tbl[i].x1, tbl[i].x2, tbl[i].st, tbl[i].lat, tbl[i].ex);

        for (int i = 0; i < 150; i++) begin
            r = W'($urandom); ai = int'(r);
            r = W'($urandom); bi = int'(r);
            r = W'($urandom); ci = int'(r);
            if ($urandom_range(0, 5) == 0) ai = 0;
            if ($urandom_range(0, 7) == 0) bi = 0;
            model(ai, bi, ci, x1e, x2e, ste, late, exe);
            run_one($sformatf("rnd%0d(%0d,%0d,%0d)", i, ai, bi, ci), ai, bi, ci, x1e, x2e, ste, late, exe);
        end

        // start held high: back-to-back accepts, busy never drops
        @(negedge clk);
        a = W'(1); b = W'(-3); c = W'(2);
        start = 1'b1;
        wait_done("held first", cyc);
        drops = 0; cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!busy) drops++;
        end while (!done && cyc < 200);
        start = 1'b0;
        chk("held interval", cyc, LQ + 1);
        chk("held busy drops", drops, 0);
        chk("held x1", to_int(x1), 2);
        chk("held x2", to_int(x2), 1);
        @(negedge clk);
        chk("held busy after release", int'(busy), 0);

        // start pulsed mid-SQRT with new coefficients is ignored
        @(negedge clk);
        a = W'(1); b = W'(1); c = W'(-1);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = W'(0); b = W'(2); c = W'(-6);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midpulse", cyc);
        chk("midpulse x1", to_int(x1), 0);
        chk("midpulse x2", to_int(x2), -1);
        chk("midpulse status", int'(status), 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || done) pulses++;
        end
        chk("midpulse no queued run", pulses, 0);

        // reset at cycle 10 of a quadratic run
        @(negedge clk);
        a = W'(1); b = W'(-3); c = W'(2);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst x1", to_int(x1), 0);
        chk("midrst x2", to_int(x2), 0);
        chk("midrst status", int'(status), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("midrst no done", pulses, 0);
        run_one("after reset", 1, -3, 2, 2, 1, 0, LQ, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
